turn_scheduler: RTL

- Game-level sequencer for Battleship.
- Owns the shared cursor unit and the board-update datapath. Decides which player's N64 button pulses drive them, and when.
- Runs the game phases: idle, P1 ship placement, P2 ship placement, alternating fire turns, game over.
- Configures cursor footprint (CursorXWidth/CursorYWidth), issues NewCursor, and request/ack handshakes toward board logic.

---
 rtl/turn_scheduler.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/turn_scheduler.sv
// Battleship game sequencer: routes one controller at a time to the shared cursor,
// runs placement and fire turns, and handshakes placements/shots with the board logic.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no game running, waiting for either Start
// PLACE      | selected player positions/rotates the current ship
// PLACE_WAIT | PlaceReq issued, waiting for board Ack (or timeout)
// FIRE       | selected player aims a 1x1 shot
// FIRE_WAIT  | FireReq issued, waiting for board Ack (or timeout)
// DONE       | game over, outputs frozen until either Start
module turn_scheduler #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TOTAL_HITS  = 17
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       P1A,
    input  logic       P1B,
    input  logic       P1Start,
    input  logic       P2A,
    input  logic       P2B,
    input  logic       P2Start,
    input  logic       Ack,
    input  logic       Ok,
    output logic       Sel,
    output logic       NewCursor,
    output logic [2:0] CursorXWidth,
    output logic [2:0] CursorYWidth,
    output logic       Orient,
    output logic [2:0] ShipIdx,
    output logic       PlaceReq,
    output logic       FireReq,
    output logic [1:0] Phase,
    output logic [4:0] P1Hits,
    output logic [4:0] P2Hits,
    output logic       GameOver,
    output logic       Winner
);

    localparam int TimerWidth = $clog2(ACK_TIMEOUT + 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PLACE      = 3'd1;
    localparam logic [2:0] PLACE_WAIT = 3'd2;
    localparam logic [2:0] FIRE       = 3'd3;
    localparam logic [2:0] FIRE_WAIT  = 3'd4;
    localparam logic [2:0] DONE       = 3'd5;

    localparam logic [1:0] PhaseIdle  = 2'd0;
    localparam logic [1:0] PhasePlace = 2'd1;
    localparam logic [1:0] PhaseFire  = 2'd2;
    localparam logic [1:0] PhaseDone  = 2'd3;

    localparam logic [2:0] LastShip = 3'd4;
    localparam logic [4:0] HitMax   = 5'd31;
    localparam logic [4:0] HitGoal  = 5'(TOTAL_HITS);

    logic [2:0]            state;
    logic [TimerWidth-1:0] ackTimer;

    logic       btnA;
    logic       btnB;
    logic       anyStart;
    logic       ackTimedOut;
    logic [4:0] selHits;
    logic [4:0] nextHits;

    function automatic logic [2:0] shipLen(input logic [2:0] idx);
        case (idx)
            3'd0:    shipLen = 3'd5;
            3'd1:    shipLen = 3'd4;
            3'd2:    shipLen = 3'd3;
            3'd3:    shipLen = 3'd3;
            default: shipLen = 3'd2;
        endcase
    endfunction

    // Only the controller currently holding the cursor is listened to.
    assign btnA     = Sel ? P2A : P1A;
    assign btnB     = Sel ? P2B : P1B;
    assign anyStart = P1Start | P2Start;

    // Expires on the ACK_TIMEOUT-th waiting cycle; a real Ack that cycle still wins.
    assign ackTimedOut = (ackTimer == TimerWidth'(ACK_TIMEOUT - 1));

    assign selHits  = Sel ? P2Hits : P1Hits;
    assign nextHits = (selHits == HitMax) ? HitMax : selHits + 5'd1;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            ackTimer     <= '0;
            Phase        <= PhaseIdle;
            Sel          <= 1'b0;
            NewCursor    <= 1'b0;
            CursorXWidth <= 3'd1;
            CursorYWidth <= 3'd1;
            Orient       <= 1'b0;
            ShipIdx      <= 3'd0;
            PlaceReq     <= 1'b0;
            FireReq      <= 1'b0;
            P1Hits       <= 5'd0;
            P2Hits       <= 5'd0;
            GameOver     <= 1'b0;
            Winner       <= 1'b0;
        end else begin
            NewCursor <= 1'b0;
            PlaceReq  <= 1'b0;
            FireReq   <= 1'b0;

            case (state)
                IDLE: begin
                    if (anyStart) begin
                        state        <= PLACE;
                        Phase        <= PhasePlace;
                        Sel          <= 1'b0;
                        ShipIdx      <= 3'd0;
                        Orient       <= 1'b0;
                        CursorXWidth <= shipLen(3'd0);
                        CursorYWidth <= 3'd1;
                        NewCursor    <= 1'b1;
                    end
                end

                PLACE: begin
                    if (btnA) begin
                        PlaceReq <= 1'b1;
                        ackTimer <= '0;
                        state    <= PLACE_WAIT;
                    end else if (btnB) begin
                        // Rehoming after a rotate keeps the new footprint on the board.
                        Orient       <= ~Orient;
                        CursorXWidth <= CursorYWidth;
                        CursorYWidth <= CursorXWidth;
                        NewCursor    <= 1'b1;
                    end
                end

                PLACE_WAIT: begin
                    ackTimer <= ackTimer + TimerWidth'(1);
                    if (Ack && Ok) begin
                        NewCursor <= 1'b1;
                        Orient    <= 1'b0;
                        if (ShipIdx != LastShip) begin
                            ShipIdx      <= ShipIdx + 3'd1;
                            CursorXWidth <= shipLen(ShipIdx + 3'd1);
                            CursorYWidth <= 3'd1;
                            state        <= PLACE;
                        end else if (!Sel) begin
                            Sel          <= 1'b1;
                            ShipIdx      <= 3'd0;
                            CursorXWidth <= shipLen(3'd0);
                            CursorYWidth <= 3'd1;
                            state        <= PLACE;
                        end else begin
                            Sel          <= 1'b0;
                            CursorXWidth <= 3'd1;
                            CursorYWidth <= 3'd1;
                            Phase        <= PhaseFire;
                            state        <= FIRE;
                        end
                    end else if (Ack || ackTimedOut) begin
                        state <= PLACE;
                    end
                end

                FIRE: begin
                    if (btnA) begin
                        FireReq  <= 1'b1;
                        ackTimer <= '0;
                        state    <= FIRE_WAIT;
                    end
                end

                FIRE_WAIT: begin
                    ackTimer <= ackTimer + TimerWidth'(1);
                    if (Ack && Ok) begin
                        if (Sel) P2Hits <= nextHits;
                        else     P1Hits <= nextHits;
                        if (nextHits == HitGoal) begin
                            GameOver <= 1'b1;
                            Winner   <= Sel;
                            Phase    <= PhaseDone;
                            state    <= DONE;
                        end else begin
                            Sel       <= ~Sel;
                            NewCursor <= 1'b1;
                            state     <= FIRE;
                        end
                    end else if (Ack || ackTimedOut) begin
                        Sel       <= ~Sel;
                        NewCursor <= 1'b1;
                        state     <= FIRE;
                    end
                end

                DONE: begin
                    if (anyStart) begin
                        state        <= IDLE;
                        ackTimer     <= '0;
                        Phase        <= PhaseIdle;
                        Sel          <= 1'b0;
                        CursorXWidth <= 3'd1;
                        CursorYWidth <= 3'd1;
                        Orient       <= 1'b0;
                        ShipIdx      <= 3'd0;
                        P1Hits       <= 5'd0;
                        P2Hits       <= 5'd0;
                        GameOver     <= 1'b0;
                        Winner       <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    Phase <= PhaseIdle;
                end
            endcase
        end
    end

endmodule
